// File: rtl/editor_hora_pkg.sv
// rtl/editor_hora_pkg.sv - shared states, field limits, cursor codes and BCD helpers for editor_hora
package editor_hora_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EDIT   = 2'd1,
        COMMIT = 2'd2
    } state_e;

    localparam logic [7:0] HORA_MAX   = 8'h23;
    localparam logic [7:0] MINSEG_MAX = 8'h59;

    localparam logic [3:0] CUR_HORA = 4'd0;
    localparam logic [3:0] CUR_MIN  = 4'd1;
    localparam logic [3:0] CUR_SEG  = 4'd2;

    // True when v is two valid BCD digits and does not exceed mx.
    function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] mx);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= mx);
    endfunction

    function automatic logic [3:0] cur_right(input logic [3:0] c);
        case (c)
            CUR_HORA: return CUR_MIN;
            CUR_MIN:  return CUR_SEG;
            default:  return CUR_HORA;
        endcase
    endfunction

    function automatic logic [3:0] cur_left(input logic [3:0] c);
        case (c)
            CUR_HORA: return CUR_SEG;
            CUR_SEG:  return CUR_MIN;
            default:  return CUR_HORA;
        endcase
    endfunction

endpackage

// File: rtl/editor_hora_if.sv
// rtl/editor_hora_if.sv - RTC bus between the hour editor (master) and the RTC bus controller (slave)
interface editor_hora_if;
    logic [7:0] rtc_HORA;
    logic [7:0] rtc_MIN;
    logic [7:0] rtc_SEG;
    logic       rtc_valid;
    logic       wr_req;
    logic       wr_ack;

    modport master (
        input  rtc_HORA,
        input  rtc_MIN,
        input  rtc_SEG,
        input  rtc_valid,
        input  wr_ack,
        output wr_req
    );

    modport slave (
        output rtc_HORA,
        output rtc_MIN,
        output rtc_SEG,
        output rtc_valid,
        output wr_ack,
        input  wr_req
    );
endinterface

// File: rtl/editor_hora_bcd_campo.sv
// rtl/editor_hora_bcd_campo.sv - one packed-BCD time field with load and wrapping up/down stepping
module bcd_campo (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] ld_val,
    input  logic       up,
    input  logic       dn,
    input  logic [7:0] max_val,
    output logic [7:0] val
);
    import editor_hora_pkg::*;

    logic [7:0] val_q, val_d;

    always_comb begin
        val_d = val_q;
        if (load) begin
            val_d = ld_val;
        end else if (up && !dn) begin
            // A corrupt field restarts from zero rather than propagating garbage.
            if (!bcd_ok(val_q, max_val) || val_q == max_val)
                val_d = 8'h00;
            else if (val_q[3:0] == 4'd9)
                val_d = {val_q[7:4] + 4'd1, 4'd0};
            else
                val_d = {val_q[7:4], val_q[3:0] + 4'd1};
        end else if (dn && !up) begin
            if (!bcd_ok(val_q, max_val) || val_q == 8'h00)
                val_d = max_val;
            else if (val_q[3:0] == 4'd0)
                val_d = {val_q[7:4] - 4'd1, 4'd9};
            else
                val_d = {val_q[7:4], val_q[3:0] - 4'd1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) val_q <= 8'h00;
        else       val_q <= val_d;
    end

    assign val = val_q;

endmodule

// File: rtl/editor_hora.sv
// rtl/editor_hora.sv - time-of-day mirror/editor with RTC write-back handshake; AUTO_REPEAT_EN enables held-button repeat
module editor_hora #(
    parameter int REPEAT_DELAY = 50_000_000,
    parameter int REPEAT_RATE  = 10_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Prog_on,
    input  logic              btn_up,
    input  logic              btn_down,
    input  logic              btn_left,
    input  logic              btn_right,
    editor_hora_if.master     rtc,
    output logic [7:0]        digit_HORA,
    output logic [7:0]        digit_MIN,
    output logic [7:0]        digit_SEG,
    output logic [3:0]        Cursor,
    output logic              editando
);
    import editor_hora_pkg::*;

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_EDIT   = EDIT;
    localparam logic [1:0] ST_COMMIT = COMMIT;

    logic [1:0] state_q, state_d;
    logic [3:0] cursor_q, cursor_d;
    logic       wr_req_q, wr_req_d;
    logic [3:0] btn_q, btn_d, btn_e;

    logic up_e, dn_e, lf_e, rt_e;
    logic in_edit, ld_all;
    logic rep_up, rep_dn;
    logic step_up, step_dn;

    assign btn_d   = {btn_up, btn_down, btn_left, btn_right};
    assign btn_e   = btn_d & ~btn_q;
    assign up_e    = btn_e[3];
    assign dn_e    = btn_e[2];
    assign lf_e    = btn_e[1];
    assign rt_e    = btn_e[0];
    assign in_edit = (state_q == ST_EDIT);
    assign ld_all  = (state_q == ST_IDLE) && rtc.rtc_valid;

`ifdef AUTO_REPEAT_EN
    localparam int CW = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY + 1) : 1;
    localparam logic [CW-1:0] DELAY_C  = CW'(REPEAT_DELAY);
    // After the first repeat the counter restarts part-way so the next fire is REPEAT_RATE later.
    localparam logic [CW-1:0] RELOAD_C = (REPEAT_RATE > REPEAT_DELAY || REPEAT_RATE < 1) ?
                                         CW'(1) : CW'(REPEAT_DELAY - REPEAT_RATE + 1);

    logic [CW-1:0] rep_q, rep_d;
    logic          rep_fire, held_up, held_dn;

    assign held_up = btn_up   && btn_q[3] && !btn_down;
    assign held_dn = btn_down && btn_q[2] && !btn_up;

    always_comb begin
        rep_d    = '0;
        rep_fire = 1'b0;
        if (!in_edit || lf_e || rt_e) begin
            rep_d = '0;
        end else if ((up_e && !btn_down) || (dn_e && !btn_up)) begin
            rep_d = CW'(1);
        end else if ((held_up || held_dn) && rep_q != '0) begin
            if (rep_q == DELAY_C) begin
                rep_fire = 1'b1;
                rep_d    = RELOAD_C;
            end else begin
                rep_d = rep_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) rep_q <= '0;
        else       rep_q <= rep_d;
    end

    assign rep_up = rep_fire && held_up;
    assign rep_dn = rep_fire && held_dn;
`else
    logic [63:0] unused_cfg;
    assign unused_cfg = {REPEAT_DELAY, REPEAT_RATE};
    assign rep_up     = 1'b0;
    assign rep_dn     = 1'b0;
`endif

    assign step_up = in_edit && (up_e || rep_up);
    assign step_dn = in_edit && (dn_e || rep_dn);

    always_comb begin
        state_d  = state_q;
        cursor_d = cursor_q;
        wr_req_d = wr_req_q;
        case (state_q)
            ST_IDLE: begin
                if (Prog_on) begin
                    state_d  = ST_EDIT;
                    cursor_d = CUR_HORA;
                end
            end
            ST_EDIT: begin
                if (rt_e && !lf_e)      cursor_d = cur_right(cursor_q);
                else if (lf_e && !rt_e) cursor_d = cur_left(cursor_q);
                if (!Prog_on) begin
                    state_d  = ST_COMMIT;
                    wr_req_d = 1'b1;
                end
            end
            ST_COMMIT: begin
                if (rtc.wr_ack) begin
                    wr_req_d = 1'b0;
                    if (Prog_on) begin
                        state_d  = ST_EDIT;
                        cursor_d = CUR_HORA;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                cursor_d = CUR_HORA;
                wr_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cursor_q <= CUR_HORA;
            wr_req_q <= 1'b0;
            btn_q    <= 4'b0000;
        end else begin
            state_q  <= state_d;
            cursor_q <= cursor_d;
            wr_req_q <= wr_req_d;
            btn_q    <= btn_d;
        end
    end

    bcd_campo u_hora (
        .clk     (clk),
        .reset   (reset),
        .load    (ld_all),
        .ld_val  (rtc.rtc_HORA),
        .up      (step_up && cursor_q == CUR_HORA),
        .dn      (step_dn && cursor_q == CUR_HORA),
        .max_val (HORA_MAX),
        .val     (digit_HORA)
    );

    bcd_campo u_min (
        .clk     (clk),
        .reset   (reset),
        .load    (ld_all),
        .ld_val  (rtc.rtc_MIN),
        .up      (step_up && cursor_q == CUR_MIN),
        .dn      (step_dn && cursor_q == CUR_MIN),
        .max_val (MINSEG_MAX),
        .val     (digit_MIN)
    );

    bcd_campo u_seg (
        .clk     (clk),
        .reset   (reset),
        .load    (ld_all),
        .ld_val  (rtc.rtc_SEG),
        .up      (step_up && cursor_q == CUR_SEG),
        .dn      (step_dn && cursor_q == CUR_SEG),
        .max_val (MINSEG_MAX),
        .val     (digit_SEG)
    );

    assign Cursor     = cursor_q;
    assign rtc.wr_req = wr_req_q;
    assign editando   = in_edit;

endmodule

// File: tb/tb_editor_hora.sv
// tb/tb_editor_hora.sv - table-driven self-checking bench for editor_hora
module tb_editor_hora;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       Prog_on = 1'b0;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic [7:0] digit_HORA, digit_MIN, digit_SEG;
    logic [3:0] Cursor;
    logic       editando;

    editor_hora_if bus();

    always #5 clk = ~clk;

    editor_hora #(.REPEAT_DELAY(10), .REPEAT_RATE(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .Prog_on    (Prog_on),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .rtc        (bus),
        .digit_HORA (digit_HORA),
        .digit_MIN  (digit_MIN),
        .digit_SEG  (digit_SEG),
        .Cursor     (Cursor),
        .editando   (editando)
    );

    localparam logic [6:0] P = 7'b1000000;
    localparam logic [6:0] U = 7'b0100000;
    localparam logic [6:0] D = 7'b0010000;
    localparam logic [6:0] L = 7'b0001000;
    localparam logic [6:0] R = 7'b0000100;
    localparam logic [6:0] V = 7'b0000010;
    localparam logic [6:0] A = 7'b0000001;

    typedef struct {
        logic [6:0]  in;
        logic [23:0] rtc;
        logic [23:0] ed;
        logic [3:0]  ec;
        logic        ewr;
        logic        eed;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic [6:0] in, input logic [23:0] r, input logic [23:0] e,
                       input logic [3:0] c, input logic w, input logic ed_);
        vec_t v;
        v.in = in; v.rtc = r; v.ed = e; v.ec = c; v.ewr = w; v.eed = ed_;
        vq.push_back(v);
    endtask

    task automatic drive(input logic [6:0] in, input logic [23:0] r);
        {Prog_on, btn_up, btn_down, btn_left, btn_right, bus.rtc_valid, bus.wr_ack} = in;
        {bus.rtc_HORA, bus.rtc_MIN, bus.rtc_SEG} = r;
    endtask

    task automatic step(input logic [6:0] in, input logic [23:0] r);
        drive(in, r);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [23:0] e, input logic [3:0] c,
                         input logic w, input logic ed_);
        logic [29:0] act, exp_v;
        act   = {digit_HORA, digit_MIN, digit_SEG, Cursor, bus.wr_req, editando};
        exp_v = {e, c, w, ed_};
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got hms=%h cur=%0d wr_req=%b editando=%b, expected hms=%h cur=%0d wr_req=%b editando=%b",
                     name, act[29:6], act[5:2], act[1], act[0], e, c, w, ed_);
        end
    endtask

    initial begin
        logic [23:0] rep_exp;

        // Mirror, load, enter EDIT, hour wrap both ways, rtc ignored in EDIT.
        add(V,     24'h123456, 24'h123456, 0, 0, 0);
        add(0,     24'h235900, 24'h123456, 0, 0, 0);
        add(V,     24'h235900, 24'h235900, 0, 0, 0);
        add(P,     24'h000000, 24'h235900, 0, 0, 1);
        add(P|U,   24'h000000, 24'h005900, 0, 0, 1);
        add(P,     24'h000000, 24'h005900, 0, 0, 1);
        add(P|D,   24'h000000, 24'h235900, 0, 0, 1);
        add(P|V,   24'h111111, 24'h235900, 0, 0, 1);
        // Minute wrap, cursor walk, simultaneous buttons.
        add(P|R,   24'h000000, 24'h235900, 1, 0, 1);
        add(P|U,   24'h000000, 24'h230000, 1, 0, 1);
        add(P,     24'h000000, 24'h230000, 1, 0, 1);
        add(P|R,   24'h000000, 24'h230000, 2, 0, 1);
        add(P,     24'h000000, 24'h230000, 2, 0, 1);
        add(P|R,   24'h000000, 24'h230000, 0, 0, 1);
        add(P|L,   24'h000000, 24'h230000, 2, 0, 1);
        add(P|U|D, 24'h000000, 24'h230000, 2, 0, 1);
        add(P,     24'h000000, 24'h230000, 2, 0, 1);
        add(P|D,   24'h000000, 24'h230059, 2, 0, 1);
        add(P|U|R, 24'h000000, 24'h230000, 0, 0, 1);
        add(P,     24'h000000, 24'h230000, 0, 0, 1);
        add(P|L|R, 24'h000000, 24'h230000, 0, 0, 1);
        add(P,     24'h000000, 24'h230000, 0, 0, 1);
        // Commit with immediate ack, then 07:08:09 commit with delayed ack.
        add(0,     24'h000000, 24'h230000, 0, 1, 0);
        add(A,     24'h000000, 24'h230000, 0, 0, 0);
        add(V,     24'h070809, 24'h070809, 0, 0, 0);
        add(P,     24'h000000, 24'h070809, 0, 0, 1);
        add(0,     24'h000000, 24'h070809, 0, 1, 0);
        add(U,     24'h000000, 24'h070809, 0, 1, 0);
        add(0,     24'h000000, 24'h070809, 0, 1, 0);
        add(V,     24'h111111, 24'h070809, 0, 1, 0);
        add(R,     24'h000000, 24'h070809, 0, 1, 0);
        add(0,     24'h000000, 24'h070809, 0, 1, 0);
        add(A,     24'h000000, 24'h070809, 0, 0, 0);
        add(0,     24'h000000, 24'h070809, 0, 0, 0);
        // Out-of-range and non-BCD fields, hour 00->23 via left walk.
        add(V,     24'h756A59, 24'h756A59, 0, 0, 0);
        add(P,     24'h000000, 24'h756A59, 0, 0, 1);
        add(P|U,   24'h000000, 24'h006A59, 0, 0, 1);
        add(P|R,   24'h000000, 24'h006A59, 1, 0, 1);
        add(P|D,   24'h000000, 24'h005959, 1, 0, 1);
        add(P|R,   24'h000000, 24'h005959, 2, 0, 1);
        add(P|U,   24'h000000, 24'h005900, 2, 0, 1);
        add(P,     24'h000000, 24'h005900, 2, 0, 1);
        add(P|L,   24'h000000, 24'h005900, 1, 0, 1);
        add(P,     24'h000000, 24'h005900, 1, 0, 1);
        add(P|L,   24'h000000, 24'h005900, 0, 0, 1);
        add(P|D,   24'h000000, 24'h235900, 0, 0, 1);
        add(P,     24'h000000, 24'h235900, 0, 0, 1);

        drive(0, 24'h0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("reset", 24'h000000, 0, 0, 0);
        reset = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].in, vq[i].rtc);
            check($sformatf("vec%0d", i), vq[i].ed, vq[i].ec, vq[i].ewr, vq[i].eed);
        end

        // Prog_on re-asserted during COMMIT returns to EDIT with cursor on hour.
        step(P|R, 24'h0); check("reedit_cur1",   24'h235900, 1, 0, 1);
        step(0,   24'h0); check("reedit_commit", 24'h235900, 1, 1, 0);
        step(P,   24'h0); check("reedit_wait",   24'h235900, 1, 1, 0);
        step(P|A, 24'h0); check("reedit_ack",    24'h235900, 0, 0, 1);

        // Held up button on second 00.
        step(P|L, 24'h0); check("rep_cursor",    24'h235900, 2, 0, 1);
        step(P,   24'h0);
        drive(P|U, 24'h0);
        repeat (20) @(negedge clk);
        drive(P, 24'h0);
        repeat (3) @(negedge clk);
`ifdef AUTO_REPEAT_EN
        rep_exp = 24'h235904;
`else
        rep_exp = 24'h235901;
`endif
        check("hold_up", rep_exp, 2, 0, 1);

        // Reset in the middle of a write request.
        step(0, 24'h0); check("commit_before_reset", rep_exp, 2, 1, 0);
        reset = 1'b1;
        step(0, 24'h0); check("reset_mid_commit", 24'h000000, 0, 0, 0);
        reset = 1'b0;
        step(U, 24'h0); check("idle_ignores_btn", 24'h000000, 0, 0, 0);
        step(V, 24'h215843); check("idle_reload", 24'h215843, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
